// File: rtl/gpio_serial_pkg.sv
// Shared types and constants for the GPIO configuration chain serializer.
package gpio_serial_pkg;

    localparam int GPIO_CFG_WIDTH = 13;

    localparam logic [GPIO_CFG_WIDTH-1:0] GPIO_CFG_INIT_DEFAULT = 13'h0402;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD,
        DONE
    } serial_state_t;

endpackage

// File: rtl/gpio_serial_tick.sv
// Phase counter: strobes phase_end on the last cycle of every CLK_DIV-cycle phase.
module gpio_serial_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic phase_end
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_q;

    assign phase_end = (cnt_q == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (phase_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/gpio_config_serializer.sv
// Shifts a snapshot of the pad configuration bank MSB-first into the GPIO
// control chain, then strobes serial_load so the chain adopts it.
module gpio_config_serializer
    import gpio_serial_pkg::*;
#(
    parameter int NUM_GPIO = 19,
    parameter int CLK_DIV  = 2
) (
    input  logic                               wb_clk_i,
    input  logic                               wb_rst_i,
    input  logic                               start,
    input  logic [NUM_GPIO*GPIO_CFG_WIDTH-1:0] cfg_words,
    output logic                               serial_clock,
    output logic                               serial_data,
    output logic                               serial_load,
    output logic                               serial_resetn,
    output logic                               busy,
    output logic                               done
);

    localparam int N  = NUM_GPIO * GPIO_CFG_WIDTH;
    localparam int BW = $clog2(N + 1);

    serial_state_t state_q, state_d;
    logic [N-1:0]  snap_q, snap_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          half_q, half_d;
    logic          sclk_d, sdata_d, sload_d, busy_d, done_d;
    logic          tick_clear, phase_end;

    // Restart the phase count whenever a timed state is entered.
    assign tick_clear = (state_d != state_q) &&
                        (state_d == SHIFT || state_d == LOAD);

    gpio_serial_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .clear    (tick_clear),
        .phase_end(phase_end)
    );

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        bit_d   = bit_q;
        half_d  = half_q;
        sclk_d  = serial_clock;
        sdata_d = serial_data;
        sload_d = serial_load;
        busy_d  = busy;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                sclk_d  = 1'b0;
                sdata_d = 1'b0;
                sload_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    state_d = SHIFT;
                    snap_d  = cfg_words;
                    bit_d   = '0;
                    half_d  = 1'b0;
                    sdata_d = cfg_words[N-1];
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (phase_end && !half_q) begin
                    half_d = 1'b1;
                    sclk_d = 1'b1;
                end else if (phase_end) begin
                    half_d = 1'b0;
                    sclk_d = 1'b0;
                    snap_d = {snap_q[N-2:0], 1'b0};
                    bit_d  = bit_q + BW'(1);
                    if (bit_q == BW'(N - 1)) begin
                        state_d = LOAD;
                        sdata_d = 1'b0;
                        sload_d = 1'b1;
                    end else begin
                        sdata_d = snap_q[N-2];
                    end
                end
            end
            LOAD: begin
                if (phase_end) begin
                    state_d = DONE;
                    sload_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= IDLE;
            snap_q        <= '0;
            bit_q         <= '0;
            half_q        <= 1'b0;
            serial_clock  <= 1'b0;
            serial_data   <= 1'b0;
            serial_load   <= 1'b0;
            serial_resetn <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            bit_q         <= bit_d;
            half_q        <= half_d;
            serial_clock  <= sclk_d;
            serial_data   <= sdata_d;
            serial_load   <= sload_d;
            serial_resetn <= 1'b1;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

endmodule
